// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Data-memory responder for a CPU MEM stage. Stores are posted into a small
//   FIFO write buffer and retired into a single-port backing array whenever
//   the array port is not needed by a load. Loads are answered combinationally,
//   forwarding from the youngest matching buffered store when one exists.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   mem_addr       byte address; word index = mem_addr[ADDR_W+1:2]
//   mem_write_data store data (already size-filtered upstream)
//   mem_wr         store request
//   mem_rd         load request (reserves the array port this cycle)
//   mem_read_data  load data, combinational, same cycle
//   mem_stall      store not accepted this cycle (buffer full)
//   wb_count       write-buffer occupancy
//   wb_empty       write buffer holds no entries
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 mem_addr,
    input  logic [31:0]                 mem_write_data,
    input  logic                        mem_wr,
    input  logic                        mem_rd,
    output logic [31:0]                 mem_read_data,
    output logic                        mem_stall,
    output logic [$clog2(WB_DEPTH):0]   wb_count,
    output logic                        wb_empty
);

    localparam int unsigned PW    = $clog2(WB_DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned WORDS = 1 << ADDR_W;

    // Backing array and write-buffer storage
    logic [31:0]        r_mem   [WORDS];
    logic [ADDR_W-1:0]  r_idx   [WB_DEPTH];
    logic [31:0]        r_data  [WB_DEPTH];
    logic [WB_DEPTH-1:0] r_valid;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;

    logic [ADDR_W-1:0]  w_idx;
    logic               w_unused_addr_bits;
    logic               w_full;
    logic               w_enq;
    logic               w_drain;
    logic               w_fwd_hit;
    logic [31:0]        w_fwd_data;

    assign w_idx              = mem_addr[ADDR_W+1:2];
    assign w_unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    // Stall looks only at current occupancy: a full buffer refuses the store
    // even if an entry drains on the same edge.
    assign w_full  = (r_count == CW'(WB_DEPTH));
    assign w_enq   = mem_wr & ~w_full;
    assign w_drain = (r_count != '0) & ~mem_rd;

    // Forwarding: walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] slot;
        slot       = '0;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int unsigned k = 0; k < WB_DEPTH; k++) begin
            slot = r_rd_ptr + PW'(k);
            if ((CW'(k) < r_count) && r_valid[slot] && (r_idx[slot] == w_idx)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[slot];
            end
        end
    end

    assign mem_read_data = reset ? '0 : (w_fwd_hit ? w_fwd_data : r_mem[w_idx]);
    assign mem_stall     = mem_wr & w_full & ~reset;
    assign wb_count      = r_count;
    assign wb_empty      = (r_count == '0);

    // Enqueue and drain never touch the same slot: enqueue needs a non-full
    // buffer and drain a non-empty one, so equal pointers imply only one fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            for (int unsigned i = 0; i < WB_DEPTH; i++) begin
                r_idx[i]  <= '0;
                r_data[i] <= '0;
            end
            for (int unsigned i = 0; i < WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_drain) begin
                r_mem[r_idx[r_rd_ptr]] <= r_data[r_rd_ptr];
                r_valid[r_rd_ptr]      <= 1'b0;
                r_rd_ptr               <= r_rd_ptr + 1'b1;
            end
            if (w_enq) begin
                r_idx[r_wr_ptr]   <= w_idx;
                r_data[r_wr_ptr]  <= mem_write_data;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Directed stimulus against mem_responder. A queue-based reference model
//   tracks the posted-store buffer and the array contents; one compare
//   process checks read data, stall and occupancy every cycle, and the
//   directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int unsigned AW = 8;
    localparam int unsigned D  = 4;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_read_data;
    logic        mem_stall;
    logic [2:0]  wb_count;
    logic        wb_empty;

    int checks;
    int errors;

    mem_responder #(.ADDR_W(AW), .WB_DEPTH(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_wr         (mem_wr),
        .mem_rd         (mem_rd),
        .mem_read_data  (mem_read_data),
        .mem_stall      (mem_stall),
        .wb_count       (wb_count),
        .wb_empty       (wb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned idx;
        logic [31:0] data;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_mem [1 << AW];

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % (1 << AW);
    endfunction

    function automatic logic [31:0] m_lookup(input logic [31:0] a);
        int unsigned ix;
        ix = widx(a);
        for (int i = m_q.size() - 1; i >= 0; i--)
            if (m_q[i].idx == ix) return m_q[i].data;
        return m_mem[ix];
    endfunction

    task automatic m_clear();
        m_q.delete();
        for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
    endtask

    always @(posedge reset) m_clear();

    always @(posedge clk) begin
        if (!reset) begin
            bit full;
            entry_t e;
            full = (m_q.size() == D);
            if (m_q.size() > 0 && !mem_rd) begin
                e = m_q.pop_front();
                m_mem[e.idx] = e.data;
            end
            if (mem_wr && !full) begin
                e.idx  = widx(mem_addr);
                e.data = mem_write_data;
                m_q.push_back(e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        #2;
        chk("model_read_data", mem_read_data, reset ? 32'h0 : m_lookup(mem_addr));
        chk("model_stall", {31'b0, mem_stall}, {31'b0, (!reset && mem_wr && m_q.size() == D)});
        chk("model_wb_count", {29'b0, wb_count}, m_q.size());
        chk("model_wb_empty", {31'b0, wb_empty}, {31'b0, (m_q.size() == 0)});
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_wr         = wr;
        mem_rd         = rd;
        mem_addr       = a;
        mem_write_data = d;
        #3;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_clear();
        reset          = 1'b1;
        mem_wr         = 1'b0;
        mem_rd         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;

        // Reset state, with a store request pending to see stall held low
        drive(1, 1, 32'h10, 32'h1234);
        chk("rst_stall", {31'b0, mem_stall}, 32'h0);
        chk("rst_read", mem_read_data, 32'h0);
        chk("rst_count", {29'b0, wb_count}, 32'h0);
        chk("rst_empty", {31'b0, wb_empty}, 32'h1);
        @(negedge clk);
        mem_wr = 1'b0;
        mem_rd = 1'b0;
        reset  = 1'b0;

        // Load after reset
        drive(0, 1, 32'h10, 0);
        chk("s28_read", mem_read_data, 32'h0);
        chk("s28_empty", {31'b0, wb_empty}, 32'h1);

        // Store then forwarded load, then array load
        drive(1, 0, 32'h20, 32'hDEADBEEF);
        drive(0, 1, 32'h20, 0);
        chk("s29_fwd_read", mem_read_data, 32'hDEADBEEF);
        chk("s29_fwd_count", {29'b0, wb_count}, 32'h1);
        drive(0, 0, 32'h0, 0);
        drive(0, 1, 32'h20, 0);
        chk("s29_arr_count", {29'b0, wb_count}, 32'h0);
        chk("s29_arr_read", mem_read_data, 32'hDEADBEEF);

        // Fill the buffer while loads hold the array port
        for (int i = 0; i < 4; i++) drive(1, 1, 32'(i * 4), 32'hA0 + 32'(i));
        drive(1, 1, 32'h10, 32'hA4);
        chk("s30_full_stall", {31'b0, mem_stall}, 32'h1);
        chk("s30_full_count", {29'b0, wb_count}, 32'h4);
        drive(1, 0, 32'h10, 32'hA4);
        chk("s30_drain_stall", {31'b0, mem_stall}, 32'h1);
        drive(1, 0, 32'h10, 32'hA4);
        chk("s30_accept_stall", {31'b0, mem_stall}, 32'h0);
        chk("s30_accept_count", {29'b0, wb_count}, 32'h3);
        for (int i = 0; i < 5; i++) drive(0, 0, 32'h0, 0);
        chk("s30_drained", {31'b0, wb_empty}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 32'(i * 4), 0);
            chk($sformatf("s30_readback%0d", i), mem_read_data, 32'hA0 + 32'(i));
        end

        // Two stores to one index: youngest wins, array ends with last
        drive(1, 1, 32'h40, 32'h1);
        drive(1, 1, 32'h40, 32'h2);
        drive(0, 1, 32'h40, 0);
        chk("s31_fwd_youngest", mem_read_data, 32'h2);
        drive(0, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 0);
        drive(0, 1, 32'h40, 0);
        chk("s31_empty", {31'b0, wb_empty}, 32'h1);
        chk("s31_array", mem_read_data, 32'h2);

        // Same-cycle load and store
        drive(1, 1, 32'h80, 32'h55);
        chk("s32_old", mem_read_data, 32'h0);
        drive(0, 1, 32'h80, 0);
        chk("s32_new", mem_read_data, 32'h55);
        drive(0, 0, 32'h0, 0);

        // Asynchronous reset with pending stores
        drive(1, 1, 32'h90, 32'h11);
        drive(1, 1, 32'h94, 32'h22);
        drive(1, 1, 32'h98, 32'h33);
        drive(0, 1, 32'h98, 0);
        chk("s33_pre_count", {29'b0, wb_count}, 32'h3);
        chk("s33_pre_read", mem_read_data, 32'h33);
        reset = 1'b1;
        #1;
        chk("s33_async_count", {29'b0, wb_count}, 32'h0);
        chk("s33_async_empty", {31'b0, wb_empty}, 32'h1);
        chk("s33_async_read", mem_read_data, 32'h0);
        @(negedge clk);
        mem_rd = 1'b0;
        reset  = 1'b0;
        drive(0, 1, 32'h90, 0);
        chk("s33_read90", mem_read_data, 32'h0);
        drive(0, 1, 32'h94, 0);
        chk("s33_read94", mem_read_data, 32'h0);
        drive(0, 1, 32'h98, 0);
        chk("s33_read98", mem_read_data, 32'h0);
        drive(0, 1, 32'h20, 0);
        chk("s33_read20", mem_read_data, 32'h0);
        drive(0, 0, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning log2 of the backing-array word count (256 words).
REQ-002 The block SHALL have parameter WB_DEPTH, default 4, meaning the number of write-buffer entries (power of two).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, on ports named clk and reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  asynchronous active-high reset.
REQ-006 Port: mem_addr  input  32  byte address from the CPU MEM stage; word index = mem_addr[ADDR_W+1:2]; bits [1:0] and upper bits are ignored.
REQ-007 Port: mem_write_data  input  32  store data, already size-filtered by the CPU.
REQ-008 Port: mem_wr  input  1  store request.
REQ-009 Port: mem_rd  input  1  load request.
REQ-010 Port: mem_read_data  output  32  load data, combinational, valid in the same cycle.
REQ-011 Port: mem_stall  output  1  store not accepted this cycle; the CPU holds the request.
REQ-012 Port: wb_count  output  log2(WB_DEPTH)+1  current write-buffer occupancy.
REQ-013 Port: wb_empty  output  1  high when wb_count is 0.

Function
REQ-014 The block SHALL contain a single-port backing array of 2^ADDR_W 32-bit words and a FIFO write buffer of WB_DEPTH entries; each entry holds {word index, data}.
REQ-015 Store: when mem_wr is 1 and mem_stall is 0, the block SHALL enqueue {index, mem_write_data} at the rising edge (posted write; zero stall cycles).
REQ-016 mem_stall SHALL equal mem_wr AND (wb_count == WB_DEPTH), combinationally; this stall is conservative and applies even in a cycle where a drain occurs.
REQ-017 Drain: in any cycle with wb_count > 0 and mem_rd == 0, the block SHALL write the oldest entry into the array at the rising edge and dequeue it; at most one drain occurs per cycle.
REQ-018 When mem_rd is 1, the block SHALL perform no drain that cycle; the array port is reserved for the load.
REQ-019 An enqueue and a drain in the same cycle SHALL leave wb_count unchanged; FIFO pointers SHALL wrap modulo WB_DEPTH.
REQ-020 Load forwarding: mem_read_data SHALL return the data of the youngest valid buffer entry whose index matches; with no match, it SHALL return the array word.
REQ-021 When mem_rd is 0, mem_read_data SHALL still be driven by the same lookup; its value is don't-care to the CPU.
REQ-022 When mem_rd and mem_wr are both 1, the load SHALL return the value before this cycle's store, and the store SHALL be enqueued per REQ-015/016.
REQ-023 Multiple buffered stores to one index SHALL drain in program order, so the array ends with the last value.
REQ-024 wb_count and wb_empty SHALL be registered-state derived and glitch-free relative to clk.

Reset
REQ-025 While reset is high, the block SHALL asynchronously set wb_count to 0, wb_empty to 1, and the FIFO pointers to 0, invalidate all entries, and clear every array word to 0.
REQ-026 Buffered stores pending at reset SHALL be discarded, with no partial drain.
REQ-027 During reset, mem_stall SHALL be 0 and mem_read_data SHALL be 0.

Verification
REQ-028 Scenario: reset, then a load of addr 0x10 -> mem_read_data = 0; wb_empty = 1.
REQ-029 Scenario: store 0xDEADBEEF to 0x20, next cycle load 0x20 -> 0xDEADBEEF returned via forwarding with wb_count = 1; after one idle cycle wb_count = 0 and a load of 0x20 returns 0xDEADBEEF from the array.
REQ-030 Scenario: hold mem_rd = 1 while issuing 4 stores to 0x0/0x4/0x8/0xC, then a 5th store -> mem_stall = 1 and wb_count = 4; release mem_rd, with the 5th store accepted on the cycle after the first drain, and all 5 values later read back correctly.
REQ-031 Scenario: store 0x1 then 0x2 to 0x40 with mem_rd held -> a load of 0x40 returns 0x2; after drain, the array holds 0x2.
REQ-032 Scenario: same-cycle mem_rd + mem_wr to 0x80 (old value 0) with data 0x55 -> mem_read_data = 0 that cycle, and 0x55 the next cycle.
REQ-033 Scenario: assert reset with wb_count = 3 -> wb_count = 0 immediately without waiting for clk, and loads of the previously stored addresses return 0.
